// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the run-state encoding, the HALT opcode and the saturating counter helper.
package fetch_pkg;

    localparam int FETCH_INST_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    localparam logic [FETCH_INST_W-1:0] HALT_OP = {FETCH_INST_W{1'b1}};

    // Retired-instruction counter sticks at its maximum instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC selection for a retiring instruction: sequential, relative or absolute.
// All arithmetic wraps modulo 2^PC_W.
module pc_next #(
    parameter int PC_W  = 11,
    parameter int OFF_W = 8
) (
    input  logic [PC_W-1:0]  pc,
    input  logic             branch_en,
    input  logic             taken,
    input  logic             branch_rel,
    input  logic [OFF_W-1:0] offset,
    input  logic [PC_W-1:0]  target,
    output logic [PC_W-1:0]  next_pc
);

    logic [PC_W-1:0] offset_ext_s;

    assign offset_ext_s = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};

    // Taken branches redirect the PC; everything else steps by one.
    always_comb begin
        next_pc = pc + {{(PC_W-1){1'b0}}, 1'b1};
        if (branch_en && taken) begin
            if (branch_rel) begin
                next_pc = pc + offset_ext_s;
            end else begin
                next_pc = target;
            end
        end else begin
            next_pc = pc + {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, drives the combinational instruction ROM
// and sequences IDLE / RUN / HALTED with restart, stall, branch and halt handling.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int PC_W       = 11,
    parameter int INST_W     = 9,
    parameter int OFF_W      = 8,
    parameter int START_ADDR = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stall,
    input  logic              BranchEn,
    input  logic              Taken,
    input  logic              BranchRel,
    input  logic [OFF_W-1:0]  Offset,
    input  logic [PC_W-1:0]   Target,
    input  logic [INST_W-1:0] InstIn,
    output logic [PC_W-1:0]   InstAddress,
    output logic [INST_W-1:0] Instr,
    output logic              Done,
    output logic [15:0]       InstCount
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    fetch_state_e      state_r;
    fetch_state_e      state_s;
    logic [PC_W-1:0]   pc_r;
    logic [PC_W-1:0]   pc_s;
    logic [PC_W-1:0]   seq_pc_s;
    logic [15:0]       count_r;
    logic [15:0]       count_s;
    logic              done_r;
    logic              done_s;
    logic              is_halt_s;

    pc_next #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_pc_next (
        .pc         (pc_r),
        .branch_en  (BranchEn),
        .taken      (Taken),
        .branch_rel (BranchRel),
        .offset     (Offset),
        .target     (Target),
        .next_pc    (seq_pc_s)
    );

    assign is_halt_s = (InstIn == HALT_OP);

    // Next-state decode; restart outranks stall, stall outranks halt, halt outranks branches.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        count_s = count_r;
        done_s  = done_r;
        case (state_r)
            ST_IDLE: begin
                pc_s = START_PC;
                if (Start) begin
                    state_s = ST_RUN;
                    count_s = 16'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (Start) begin
                    pc_s    = START_PC;
                    count_s = 16'd0;
                end else if (Stall) begin
                    pc_s = pc_r;
                end else if (is_halt_s) begin
                    state_s = ST_HALTED;
                    done_s  = 1'b1;
                end else begin
                    pc_s    = seq_pc_s;
                    count_s = sat_inc(count_r);
                end
            end
            ST_HALTED: begin
                if (Start) begin
                    state_s = ST_RUN;
                    pc_s    = START_PC;
                    count_s = 16'd0;
                    done_s  = 1'b0;
                end else begin
                    state_s = ST_HALTED;
                end
            end
            default: begin
                state_s = ST_IDLE;
                pc_s    = START_PC;
                count_s = 16'd0;
                done_s  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset that overrides every other input.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            pc_r    <= START_PC;
            count_r <= 16'd0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            count_r <= count_s;
            done_r  <= done_s;
        end
    end

    // The ROM is combinational, so the fetched word is forwarded in the same cycle.
    always_comb begin
        if (state_r == ST_RUN) begin
            Instr = InstIn;
        end else begin
            Instr = {INST_W{1'b0}};
        end
    end

    assign InstAddress = pc_r;
    assign Done        = done_r;
    assign InstCount   = count_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed cycles push hand-computed expectations,
// a monitor pops and compares them just after each rising edge.
module tb_inst_fetch;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Stall;
    logic        BranchEn;
    logic        Taken;
    logic        BranchRel;
    logic [7:0]  Offset;
    logic [10:0] Target;
    logic [8:0]  InstIn;
    logic [10:0] InstAddress;
    logic [8:0]  Instr;
    logic        Done;
    logic [15:0] InstCount;

    logic [8:0]  rom [0:2047];

    typedef struct packed {
        logic [10:0] addr;
        logic        done;
        logic [15:0] cnt;
        logic [8:0]  instr;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    inst_fetch #(
        .PC_W       (11),
        .INST_W     (9),
        .OFF_W      (8),
        .START_ADDR (0)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Stall       (Stall),
        .BranchEn    (BranchEn),
        .Taken       (Taken),
        .BranchRel   (BranchRel),
        .Offset      (Offset),
        .Target      (Target),
        .InstIn      (InstIn),
        .InstAddress (InstAddress),
        .Instr       (Instr),
        .Done        (Done),
        .InstCount   (InstCount)
    );

    assign InstIn = rom[InstAddress];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, req);
        end
    endtask

    // Monitor: one expectation per rising edge, compared after outputs settle.
    always @(posedge Clk) begin
        exp_t  e;
        string nm;
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, "addr",  32'(InstAddress), 32'(e.addr));
            chk(nm, "done",  32'(Done),        32'(e.done));
            chk(nm, "count", 32'(InstCount),   32'(e.cnt));
            chk(nm, "instr", 32'(Instr),       32'(e.instr));
        end
    end

    task automatic cyc(input logic rst, input logic st, input logic stl,
                       input logic ben, input logic tk, input logic brel,
                       input logic [7:0] off, input logic [10:0] tgt,
                       input logic [10:0] e_addr, input logic e_done,
                       input logic [15:0] e_cnt, input logic e_run, input string nm);
        exp_t e;
        @(negedge Clk);
        Reset     = rst;
        Start     = st;
        Stall     = stl;
        BranchEn  = ben;
        Taken     = tk;
        BranchRel = brel;
        Offset    = off;
        Target    = tgt;
        e.addr    = e_addr;
        e.done    = e_done;
        e.cnt     = e_cnt;
        e.instr   = e_run ? rom[e_addr] : 9'h000;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic seq(input logic [10:0] e_addr, input logic [15:0] e_cnt, input string nm);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 11'd0, e_addr, 1'b0, e_cnt, 1'b1, nm);
    endtask

    task automatic jabs(input logic [10:0] tgt, input logic [15:0] e_cnt, input string nm);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, tgt, tgt, 1'b0, e_cnt, 1'b1, nm);
    endtask

    task automatic jrel(input logic [7:0] off, input logic [10:0] e_addr, input logic [15:0] e_cnt, input string nm);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, off, 11'd0, e_addr, 1'b0, e_cnt, 1'b1, nm);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            rom[i] = 9'((i * 7 + 3) % 500);
        end
        rom[12] = 9'h1FF;
        Reset = 1'b1; Start = 1'b0; Stall = 1'b0; BranchEn = 1'b0;
        Taken = 1'b0; BranchRel = 1'b0; Offset = 8'h00; Target = 11'd0;

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 11'd0, 11'd0, 1'b0, 16'd0, 1'b0, "reset0");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 11'd0, 11'd0, 1'b0, 16'd0, 1'b0, "reset1");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 11'd0, 11'd0, 1'b0, 16'd0, 1'b0, "idle_hold");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 11'd0, 11'd0, 1'b0, 16'd0, 1'b1, "start");
        seq(11'd1, 16'd1, "seq1");
        seq(11'd2, 16'd2, "seq2");
        seq(11'd3, 16'd3, "seq3");
        jabs(11'd5, 16'd4, "abs_to5");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 11'd99, 11'd6, 1'b0, 16'd5, 1'b1, "br_not_taken");
        seq(11'd7, 16'd6, "seq7");
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 11'd100, 11'd7, 1'b0, 16'd6, 1'b1, "stall");
        end
        seq(11'd8, 16'd7, "stall_release");
        jabs(11'd5, 16'd8, "abs_back5");
        jabs(11'd40, 16'd9, "abs_to40");
        jrel(8'hFC, 11'd36, 16'd10, "rel_m4");
        jabs(11'h7FF, 16'd11, "abs_top");
        seq(11'd0, 16'd12, "wrap_seq");
        seq(11'd1, 16'd13, "seq1b");
        seq(11'd2, 16'd14, "seq2b");
        jrel(8'hFC, 11'h7FE, 16'd15, "rel_wrap");
        jabs(11'd10, 16'd16, "abs_to10");
        seq(11'd11, 16'd17, "seq11");
        seq(11'd12, 16'd18, "seq12_haltword");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 11'd50, 11'd12, 1'b1, 16'd18, 1'b0, "halt");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 11'd0, 11'd12, 1'b1, 16'd18, 1'b0, "halt_hold");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 11'd0, 11'd0, 1'b0, 16'd0, 1'b1, "restart_halt");
        seq(11'd1, 16'd1, "seq1c");
        jabs(11'd20, 16'd2, "abs_to20");
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 11'd77, 11'd0, 1'b0, 16'd0, 1'b1, "restart_run");
        jabs(11'd20, 16'd1, "abs_to20b");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 11'd0, 11'd0, 1'b0, 16'd0, 1'b0, "reset_midrun");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 11'd0, 11'd0, 1'b0, 16'd0, 1'b0, "idle_after_reset");

        @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit that drives the instruction memory's address port and consumes its 9-bit instruction word. Holds the program counter and sequences it through reset, start, sequential fetch, branches, stalls and halt. Sits between the core control/decode logic and the combinational instruction ROM; the ROM's address input is this block's `InstAddress` output, and the ROM's data output is this block's `InstIn`.

## Interface
- `PC_W`, 11: program counter / ROM address width.
- `INST_W`, 9: instruction word width.
- `OFF_W`, 8: signed relative-branch offset width.
- `START_ADDR`, 0: first address fetched after start.
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  level; starts or restarts a program run.
- `Stall`  in  1  hold PC this cycle.
- `BranchEn`  in  1  current instruction is a branch.
- `Taken`  in  1  branch condition is true; only meaningful with `BranchEn`.
- `BranchRel`  in  1  1 = relative branch (`Offset`), 0 = absolute branch (`Target`).
- `Offset`  in  OFF_W  signed two's-complement offset.
- `Target`  in  PC_W  absolute branch target.
- `InstIn`  in  INST_W  instruction word returned by the ROM.
- `InstAddress`  out  PC_W  fetch address; equals the PC register.
- `Instr`  out  INST_W  `InstIn` passed through; forced to 0 when not RUN.
- `Done`  out  1  registered; high while HALTED.
- `InstCount`  out  16  count of retired instructions in the current run; saturates at 16'hFFFF.

## Operation
- States: IDLE, RUN, HALTED.
- Reset (any state): PC←START_ADDR, state←IDLE, Done←0, InstCount←0.
- IDLE: PC holds at START_ADDR. Start=1 → RUN on the next edge; PC stays START_ADDR.
- RUN, per edge, in priority order:
  - Start=1 → restart: PC←START_ADDR, InstCount←0, stay in RUN.
  - Stall=1 → PC, state and count hold; branch inputs are ignored.
  - InstIn == all-ones (HALT opcode) → HALTED, PC holds at the halt address, Done←1. The HALT instruction is not counted.
  - BranchEn & Taken & BranchRel → PC←PC + sign-extended Offset (mod 2^PC_W).
  - BranchEn & Taken & !BranchRel → PC←Target.
  - Otherwise → PC←PC+1 (mod 2^PC_W).
  - Each non-stalled, non-halt, non-restart edge increments InstCount, saturating.
- HALTED: PC, InstCount and Done hold. Start=1 → RUN with PC←START_ADDR, InstCount←0, Done←0.
- Wrap-around: incrementing or relative-branching past 2^PC_W−1 wraps modulo 2^PC_W and raises no error.
- A HALT word outranks a simultaneous BranchEn.

## Timing
- Zero-latency fetch: the ROM is combinational, so `Instr` is valid in the same cycle `InstAddress` changes.
- Branch resolution takes one cycle: the target is fetched the cycle after the branch is presented. There are no delay slots.
- `Done` rises on the edge that detects HALT and falls on the edge that accepts Start.
- Reset mid-run takes effect on the next edge and overrides Start and Stall.
- Output reset values: InstAddress = START_ADDR, Instr = 0, Done = 0, InstCount = 0.

## Structure
- Package `fetch_pkg`: state enum (IDLE/RUN/HALTED) and the HALT opcode constant (all-ones, INST_W bits).
- Optional sub-module `pc_next`: combinational next-PC mux and adder (sequential / relative / absolute). Everything else lives in `inst_fetch`.

## Test plan
- Reset, then Start for 1 cycle, feeding a ROM model with no branches → InstAddress runs 0,1,2,3; InstCount = 3 after 3 retirements.
- At PC=5, absolute branch to Target=11'd40 → next InstAddress = 40. At PC=40, relative branch with Offset=8'hFC → next InstAddress = 36.
- Stall held 3 cycles at PC=7 → InstAddress stays 7 and InstCount is frozen; after release, PC=8.
- ROM word 9'h1FF at address 12 → Done=1 on the next edge, InstAddress holds 12, Instr=0; Start then → PC=0, Done=0, InstCount=0.
- PC=11'h7FF with a sequential fetch → PC wraps to 0. PC=2 with relative Offset=-4 → PC = 11'h7FE.
- Reset asserted mid-run at PC=20 together with Start and Stall → next edge: state IDLE, PC=0, Done=0, InstCount=0.
